// File: rtl/board_mem_arbiter.sv
// Shares the single-port board-state RAM between the draw path and the game logic.
// Optional starvation guard for the logic port is built when ARB_STARVE_GUARD_EN is defined.
module board_mem_arbiter #(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 10,
  parameter int STARVE_LIM = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        button_num,
  input  logic              vblank,
  input  logic              draw_req,
  input  logic [4:0]        draw_row,
  input  logic [4:0]        draw_col,
  output logic              draw_gnt,
  output logic              draw_rvalid,
  output logic [DATA_W-1:0] draw_rdata,
  input  logic              logic_req,
  input  logic              logic_we,
  input  logic [4:0]        logic_row,
  input  logic [4:0]        logic_col,
  input  logic [DATA_W-1:0] logic_wdata,
  output logic              logic_gnt,
  output logic              logic_rvalid,
  output logic [DATA_W-1:0] logic_rdata,
  output logic              oob_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_BLANK  = 2'd1;
  localparam logic [1:0] ST_GUARD  = 2'd2;

  if (ADDR_W < 10 || STARVE_LIM < 2) begin : g_param_chk
    $error("board_mem_arbiter: ADDR_W must be >= 10 and STARVE_LIM >= 2");
  end

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row,
                                                  input logic [4:0] col,
                                                  input logic [4:0] n);
    cell_addr = ADDR_W'(row) * ADDR_W'(n) + ADDR_W'(col);
  endfunction

  logic [1:0]        state_q, state_d;
  logic              last_logic_q, last_logic_d;
  logic              gnt_d, gnt_l;
  logic              starve_p0;

  logic              xfer_p0, we_p0, oob_p0;
  logic [4:0]        row_p0, col_p0;
  logic [ADDR_W-1:0] addr_p0;

  logic              mem_en_p1_q, mem_en_p1_d;
  logic              mem_we_p1_q, mem_we_p1_d;
  logic [ADDR_W-1:0] mem_addr_p1_q, mem_addr_p1_d;
  logic [DATA_W-1:0] mem_wdata_p1_q, mem_wdata_p1_d;
  logic              oob_p1_q, oob_p1_d;
  logic              rd_p1_q, rd_p1_d;
  logic              own_p1_q, own_p1_d;

  logic              draw_vld_p2_q, draw_vld_p2_d;
  logic              logic_vld_p2_q, logic_vld_p2_d;
  logic              zero_p2_q, zero_p2_d;
  logic [DATA_W-1:0] draw_hold_q, draw_hold_d;
  logic [DATA_W-1:0] logic_hold_q, logic_hold_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CTR_W = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;

  function automatic logic [CTR_W-1:0] ctr_sat_inc(input logic [CTR_W-1:0] v);
    ctr_sat_inc = (v == CTR_W'(STARVE_LIM - 1)) ? v : v + 1'b1;
  endfunction

  logic [CTR_W-1:0] wait_ctr_q, wait_ctr_d;

  always_comb begin
    wait_ctr_d = wait_ctr_q;
    if (gnt_l) begin
      wait_ctr_d = '0;
    end else if (logic_req) begin
      wait_ctr_d = ctr_sat_inc(wait_ctr_q);
    end
    starve_p0 = (wait_ctr_d == CTR_W'(STARVE_LIM - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_ctr_q <= '0;
    end else begin
      wait_ctr_q <= wait_ctr_d;
    end
  end
`else
  assign starve_p0 = 1'b0;
`endif

  // Stage 0: arbitration, address and range check in the grant cycle
  always_comb begin
    gnt_d = 1'b0;
    gnt_l = 1'b0;
    if (rst) begin
      case (state_q)
        ST_GUARD: gnt_l = logic_req;
        ST_BLANK: begin
          if (draw_req && logic_req) begin
            gnt_l = ~last_logic_q;
            gnt_d = last_logic_q;
          end else begin
            gnt_d = draw_req;
            gnt_l = logic_req;
          end
        end
        default: begin
          gnt_d = draw_req;
          gnt_l = logic_req & ~draw_req;
        end
      endcase
    end

    xfer_p0 = gnt_d | gnt_l;
    row_p0  = gnt_l ? logic_row : draw_row;
    col_p0  = gnt_l ? logic_col : draw_col;
    we_p0   = gnt_l & logic_we;
    oob_p0  = (row_p0 >= button_num) || (col_p0 >= button_num);
    addr_p0 = cell_addr(row_p0, col_p0, button_num);

    state_d      = starve_p0 ? ST_GUARD : (vblank ? ST_BLANK : ST_ACTIVE);
    last_logic_d = xfer_p0 ? gnt_l : last_logic_q;

    mem_en_p1_d    = xfer_p0 & ~oob_p0;
    mem_we_p1_d    = xfer_p0 & ~oob_p0 & we_p0;
    mem_addr_p1_d  = xfer_p0 ? addr_p0 : mem_addr_p1_q;
    mem_wdata_p1_d = (xfer_p0 & we_p0) ? logic_wdata : mem_wdata_p1_q;
    oob_p1_d       = xfer_p0 & oob_p0;
    rd_p1_d        = xfer_p0 & ~we_p0;
    own_p1_d       = gnt_l;
  end

  // Stage 1 -> 2: route the returning read to its owner; out-of-range reads return zero
  always_comb begin
    draw_vld_p2_d  = rd_p1_q & ~own_p1_q;
    logic_vld_p2_d = rd_p1_q & own_p1_q;
    zero_p2_d      = oob_p1_q;

    draw_rdata   = draw_hold_q;
    logic_rdata  = logic_hold_q;
    if (draw_vld_p2_q) begin
      draw_rdata = zero_p2_q ? '0 : mem_rdata;
    end
    if (logic_vld_p2_q) begin
      logic_rdata = zero_p2_q ? '0 : mem_rdata;
    end
    draw_hold_d  = draw_rdata;
    logic_hold_d = logic_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_ACTIVE;
      last_logic_q   <= 1'b0;
      mem_en_p1_q    <= 1'b0;
      mem_we_p1_q    <= 1'b0;
      mem_addr_p1_q  <= '0;
      mem_wdata_p1_q <= '0;
      oob_p1_q       <= 1'b0;
      rd_p1_q        <= 1'b0;
      own_p1_q       <= 1'b0;
      draw_vld_p2_q  <= 1'b0;
      logic_vld_p2_q <= 1'b0;
      zero_p2_q      <= 1'b0;
      draw_hold_q    <= '0;
      logic_hold_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_logic_q   <= last_logic_d;
      mem_en_p1_q    <= mem_en_p1_d;
      mem_we_p1_q    <= mem_we_p1_d;
      mem_addr_p1_q  <= mem_addr_p1_d;
      mem_wdata_p1_q <= mem_wdata_p1_d;
      oob_p1_q       <= oob_p1_d;
      rd_p1_q        <= rd_p1_d;
      own_p1_q       <= own_p1_d;
      draw_vld_p2_q  <= draw_vld_p2_d;
      logic_vld_p2_q <= logic_vld_p2_d;
      zero_p2_q      <= zero_p2_d;
      draw_hold_q    <= draw_hold_d;
      logic_hold_q   <= logic_hold_d;
    end
  end

  assign draw_gnt     = gnt_d;
  assign logic_gnt    = gnt_l;
  assign mem_en       = mem_en_p1_q;
  assign mem_we       = mem_we_p1_q;
  assign mem_addr     = mem_addr_p1_q;
  assign mem_wdata    = mem_wdata_p1_q;
  assign oob_err      = oob_p1_q;
  assign draw_rvalid  = draw_vld_p2_q;
  assign logic_rvalid = logic_vld_p2_q;

endmodule
